lab_ctrl: RTL and testbench
===========================

# lab_ctrl

SPI command controller between `spi_slaver` and the ADC/DAC sample paths. Decodes byte frames received over SPI into DAC sample streams, ADC sample read-back streams and control-register accesses. Drives the SPI transmit byte and the ADC/DAC run/divider configuration. Arbitrates the single SPI byte channel between the ADC, the DAC and the register file, one frame (CS low period) at a time.

## Interface
Parameters:
- `DATA_W`, 8, sample and SPI byte width (only 8 supported)

Ports:
- `clk` in 1: system clock (PLL output).
- `resetn` in 1: asynchronous, active-low reset.
- `spi_cs` in 1: raw SPI chip select, active low, asynchronous to `clk`.
- `rxd_out` in 8: received SPI byte; valid when `rxd_flag` is high.
- `rxd_flag` in 1: one-cycle pulse per received byte.
- `txd_data` out 8: byte shifted out on the next SPI byte.
- `adc_valid` in 1: ADC sample buffer not empty.
- `adc_data` in 8: head sample of the ADC buffer.
- `adc_pop` out 1: one-cycle pop of the ADC buffer.
- `dac_ready` in 1: DAC sample buffer can accept a byte.
- `dac_wr` out 1: one-cycle DAC write strobe.
- `dac_wdata` out 8: DAC sample; valid with `dac_wr`.
- `adc_run`, `dac_run` out 1 each: CTRL[0], CTRL[1].
- `adc_div`, `dac_div` out 8 each: sample-rate divider registers.
- `busy` out 1: high while a frame is active (state ≠ IDLE).

## Operation
- `spi_cs` passes through a 2-FF synchronizer to give `cs_s`. A frame starts when `cs_s` falls and ends when `cs_s` rises.
- States: IDLE, CMD, DAC_STREAM, ADC_STREAM, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DISCARD.
- **IDLE:** moves to CMD when `cs_s` is low. `rxd_flag` is ignored while `cs_s` is high.
- **CMD:** the first byte selects the opcode:
  - 0x01 → DAC_STREAM.
  - 0x02 → ADC_STREAM.
  - 0x03 → WR_ADDR.
  - 0x04 → RD_ADDR.
  - Any other value → DISCARD, and STATUS[2] (bad_cmd) is set.
- **DAC_STREAM:** on each byte, if `dac_ready` is high, pulse `dac_wr` with `dac_wdata` = byte. Otherwise drop the byte and set STATUS[1] (dac_overflow).
- **ADC_STREAM:** on entry, and on every later byte, pop one sample.
  - `txd_data` = `adc_data` when `adc_valid` is high.
  - Otherwise `txd_data` = 0x00, no pop is issued, and STATUS[0] (adc_underrun) is set.
  - Received bytes are don't-care.
  - The sample prefetched for the byte after the last one is lost when CS rises.
- **WR_ADDR → WR_DATA:** the first byte latches the address (bits [1:0]; upper bits ignored). The next byte writes the register, then the FSM goes to DISCARD. A write to STATUS is ignored.
- **RD_ADDR → RD_DATA:** the address byte loads the selected register into `txd_data`. The next byte completes the read, then the FSM goes to DISCARD.
- Registers (8 bits each):
  - 0 CTRL, reset 0x00.
  - 1 ADC_DIV, reset 0x00.
  - 2 DAC_DIV, reset 0x00.
  - 3 STATUS, read-only, reset 0x00.
- STATUS clears when a read of address 3 completes (the RD_DATA byte). An event in the same cycle as the clear wins, so the bit stays set.
- A `cs_s` rise in any state forces IDLE on the next cycle. Any partial WR (no data byte received) performs no write. `txd_data` is then set to 0x00.
- Reset: every output is 0; the FSM is in IDLE.

## Timing
- CS synchronizer latency: 2 `clk` cycles.
- `dac_wr`, `adc_pop` and `txd_data` updates are registered. Each occurs exactly 1 cycle after the `rxd_flag` that causes it.
- A register write takes effect on the outputs 1 cycle after the data byte's `rxd_flag`.
- `rxd_flag` pulses are assumed at least 4 `clk` cycles apart.
- `adc_pop` and `dac_wr` are never high for more than 1 cycle per byte.

## Configuration
- `LAB_CTRL_STATUS_EN` defined:
  - STATUS sticky bits and clear-on-read are implemented.
  - Opcodes 0x03/0x04 are supported as above.
- Not defined:
  - No sticky bits are implemented.
  - STATUS reads 0x00.
  - Unknown opcodes still go to DISCARD silently.

## Structure
- Package `lab_pkg` holds:
  - opcode constants (`OP_DAC_STREAM` = 0x01, `OP_ADC_STREAM` = 0x02, `OP_WR_REG` = 0x03, `OP_RD_REG` = 0x04);
  - register address constants;
  - STATUS bit indices;
  - the FSM state enum.
- One sub-module, `sync_2ff`, for `spi_cs`.

## Test plan
- Reset, then frame {0x03, 0x00, 0x03} → `adc_run` = 1 and `dac_run` = 1 one cycle after the 3rd byte. Frame {0x04, 0x00, xx} → `txd_data` = 0x03 after byte 2.
- Frame {0x01, 0x10, 0x20, 0x30} with `dac_ready` = 1 → 3 `dac_wr` pulses carrying 0x10, 0x20, 0x30. Repeat with `dac_ready` = 0 on 0x20 → only 2 writes, and a STATUS read returns 0x02, then 0x00 on the next read.
- ADC buffer holds 0xA1, 0xA2; frame {0x02, xx, xx, xx} → `txd_data` sequence 0xA1, 0xA2, 0x00; STATUS[0] = 1.
- Frame {0x7F, 0x55} → no writes and no pops; STATUS = 0x04. Frame {0x03, 0x01} then CS high → ADC_DIV stays 0x00; FSM returns to IDLE within 3 cycles.
- `rxd_flag` pulsed with CS high → no outputs change. `resetn` asserted mid DAC_STREAM → all outputs 0 immediately; next frame decodes from CMD.
- Build without `LAB_CTRL_STATUS_EN`, force a DAC overflow and read address 3 → 0x00.

Source files
------------

// File: rtl/lab_pkg.sv
// Shared opcodes, register map, STATUS bit positions and FSM states for lab_ctrl.
package lab_pkg;

  localparam logic [7:0] OP_DAC_STREAM = 8'h01;
  localparam logic [7:0] OP_ADC_STREAM = 8'h02;
  localparam logic [7:0] OP_WR_REG     = 8'h03;
  localparam logic [7:0] OP_RD_REG     = 8'h04;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_ADC_DIV = 2'd1;
  localparam logic [1:0] ADDR_DAC_DIV = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int ST_ADC_UNDERRUN = 0;
  localparam int ST_DAC_OVERFLOW = 1;
  localparam int ST_BAD_CMD      = 2;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    DAC_STREAM,
    ADC_STREAM,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_DATA,
    DISCARD
  } state_t;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_DAC_STREAM) || (op == OP_ADC_STREAM) ||
           (op == OP_WR_REG) || (op == OP_RD_REG);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level signals (SPI chip select).
module sync_2ff #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        meta_reg[gi] <= RESET_VAL;
        sync_reg[gi] <= RESET_VAL;
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/lab_ctrl.sv
// SPI command controller: decodes CS-framed byte streams into DAC writes, ADC read-back and register access.
// Build option: define LAB_CTRL_STATUS_EN for sticky STATUS bits with clear-on-read.
module lab_ctrl
  import lab_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_cs,
  input  logic [DATA_W-1:0] rxd_out,
  input  logic              rxd_flag,
  output logic [DATA_W-1:0] txd_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_pop,
  input  logic              dac_ready,
  output logic              dac_wr,
  output logic [DATA_W-1:0] dac_wdata,
  output logic              adc_run,
  output logic              dac_run,
  output logic [DATA_W-1:0] adc_div,
  output logic [DATA_W-1:0] dac_div,
  output logic              busy
);

  logic              cs_s;
  logic              rx_fire;
  logic              prefetch;
  state_t            state_reg;
  logic [1:0]        addr_reg;
  logic [DATA_W-1:0] ctrl_reg;
  logic [DATA_W-1:0] adc_div_reg;
  logic [DATA_W-1:0] dac_div_reg;
  logic [DATA_W-1:0] status_reg;
  logic [DATA_W-1:0] txd_reg;
  logic [DATA_W-1:0] dac_wdata_reg;
  logic              dac_wr_reg;
  logic              adc_pop_reg;
  logic [DATA_W-1:0] rd_data;

  // CS idles high, so the synchronizer resets to 1 to avoid a phantom frame.
  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (spi_cs),
    .q      (cs_s)
  );

  assign rx_fire  = rxd_flag && !cs_s;
  assign prefetch = rx_fire && (((state_reg == CMD) && (rxd_out == OP_ADC_STREAM)) ||
                                (state_reg == ADC_STREAM));

  always_comb begin
    rd_data = '0;
    case (rxd_out[1:0])
      ADDR_CTRL:    rd_data = ctrl_reg;
      ADDR_ADC_DIV: rd_data = adc_div_reg;
      ADDR_DAC_DIV: rd_data = dac_div_reg;
      ADDR_STATUS:  rd_data = status_reg;
      default:      rd_data = '0;
    endcase
  end

`ifdef LAB_CTRL_STATUS_EN
  logic [DATA_W-1:0] status_next;

  // Clear first, then OR in this cycle's events so a coincident event survives the clear.
  always_comb begin
    status_next = status_reg;
    if (rx_fire && (state_reg == RD_DATA) && (addr_reg == ADDR_STATUS))
      status_next = '0;
    if (prefetch && !adc_valid)
      status_next[ST_ADC_UNDERRUN] = 1'b1;
    if (rx_fire && (state_reg == DAC_STREAM) && !dac_ready)
      status_next[ST_DAC_OVERFLOW] = 1'b1;
    if (rx_fire && (state_reg == CMD) && !is_known_op(rxd_out))
      status_next[ST_BAD_CMD] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) status_reg <= '0;
    else         status_reg <= status_next;
  end
`else
  assign status_reg = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      ctrl_reg      <= '0;
      adc_div_reg   <= '0;
      dac_div_reg   <= '0;
      txd_reg       <= '0;
      dac_wdata_reg <= '0;
      dac_wr_reg    <= 1'b0;
      adc_pop_reg   <= 1'b0;
    end else begin
      dac_wr_reg  <= 1'b0;
      adc_pop_reg <= 1'b0;
      if (cs_s) begin
        // Frame aborted or finished: drop any half-done access.
        if (state_reg != IDLE) begin
          state_reg <= IDLE;
          txd_reg   <= '0;
        end
      end else begin
        case (state_reg)
          IDLE: state_reg <= CMD;
          CMD: if (rxd_flag) begin
            case (rxd_out)
              OP_DAC_STREAM: state_reg <= DAC_STREAM;
              OP_ADC_STREAM: state_reg <= ADC_STREAM;
              OP_WR_REG:     state_reg <= WR_ADDR;
              OP_RD_REG:     state_reg <= RD_ADDR;
              default:       state_reg <= DISCARD;
            endcase
          end
          DAC_STREAM: if (rxd_flag && dac_ready) begin
            dac_wr_reg    <= 1'b1;
            dac_wdata_reg <= rxd_out;
          end
          WR_ADDR: if (rxd_flag) begin
            addr_reg  <= rxd_out[1:0];
            state_reg <= WR_DATA;
          end
          WR_DATA: if (rxd_flag) begin
            case (addr_reg)
              ADDR_CTRL:    ctrl_reg    <= rxd_out;
              ADDR_ADC_DIV: adc_div_reg <= rxd_out;
              ADDR_DAC_DIV: dac_div_reg <= rxd_out;
              default:      ;
            endcase
            state_reg <= DISCARD;
          end
          RD_ADDR: if (rxd_flag) begin
            addr_reg  <= rxd_out[1:0];
            txd_reg   <= rd_data;
            state_reg <= RD_DATA;
          end
          RD_DATA: if (rxd_flag) state_reg <= DISCARD;
          ADC_STREAM, DISCARD: ;
          default: state_reg <= IDLE;
        endcase
        if (prefetch) begin
          txd_reg     <= adc_valid ? adc_data : '0;
          adc_pop_reg <= adc_valid;
        end
      end
    end
  end

  assign txd_data  = txd_reg;
  assign adc_pop   = adc_pop_reg;
  assign dac_wr    = dac_wr_reg;
  assign dac_wdata = dac_wdata_reg;
  assign adc_run   = ctrl_reg[0];
  assign dac_run   = ctrl_reg[1];
  assign adc_div   = adc_div_reg;
  assign dac_div   = dac_div_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_lab_ctrl.sv
// Scoreboard bench for lab_ctrl: a frame-level reference model predicts each byte's effect.
module tb_lab_ctrl;

`ifdef LAB_CTRL_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn, spi_cs, rxd_flag, adc_valid, dac_ready;
  logic [7:0] rxd_out, adc_data;
  logic [7:0] txd_data, dac_wdata, adc_div, dac_div;
  logic       adc_pop, dac_wr, adc_run, dac_run, busy;

  always #5 clk = ~clk;

  lab_ctrl #(.DATA_W(8)) dut (
    .clk(clk), .resetn(resetn), .spi_cs(spi_cs), .rxd_out(rxd_out), .rxd_flag(rxd_flag),
    .txd_data(txd_data), .adc_valid(adc_valid), .adc_data(adc_data), .adc_pop(adc_pop),
    .dac_ready(dac_ready), .dac_wr(dac_wr), .dac_wdata(dac_wdata), .adc_run(adc_run),
    .dac_run(dac_run), .adc_div(adc_div), .dac_div(dac_div), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] txd;
    bit         pop;
    bit         wr;
    logic [7:0] wdata;
    logic [7:0] ctrl, adiv, ddiv;
  } exp_t;

  exp_t exp_q[$];

  // ADC sample buffer seen by the DUT; it drains only on real adc_pop pulses.
  logic [7:0] env_adc[$];
  always @(posedge clk) if (adc_pop && env_adc.size() > 0) env_adc.delete(0);
  always @(negedge clk) begin
    adc_valid = (env_adc.size() != 0);
    adc_data  = adc_valid ? env_adc[0] : 8'hEE;
  end

  // Reference model: register map, sticky status and the samples the ADC should deliver.
  logic [7:0] m_reg [4];
  logic [7:0] m_status, m_txd, m_op;
  logic [1:0] m_addr;
  logic [7:0] m_adc[$];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_reg[k] = 8'h00;
    m_status = 8'h00;
    m_txd    = 8'h00;
  endtask

  task automatic adc_push(input logic [7:0] v);
    env_adc.push_back(v);
    m_adc.push_back(v);
  endtask

  task automatic adc_fetch(output bit popped);
    if (m_adc.size() > 0) begin
      m_txd  = m_adc.pop_front();
      popped = 1'b1;
    end else begin
      m_txd       = 8'h00;
      popped      = 1'b0;
      m_status[0] = 1'b1;
    end
  endtask

  task automatic model_byte(input int i, input logic [7:0] b, input bit rdy, output exp_t e);
    bit p;
    e.pop = 1'b0; e.wr = 1'b0; e.wdata = 8'h00;
    if (i == 0) begin
      m_op = b;
      if (b == 8'h02) begin
        adc_fetch(p);
        e.pop = p;
      end else if (!(b inside {8'h01, 8'h02, 8'h03, 8'h04})) begin
        m_status[2] = 1'b1;
      end
    end else begin
      case (m_op)
        8'h01: if (rdy) begin e.wr = 1'b1; e.wdata = b; end else m_status[1] = 1'b1;
        8'h02: begin adc_fetch(p); e.pop = p; end
        8'h03: if (i == 1) m_addr = b[1:0];
               else if (i == 2 && m_addr != 2'd3) m_reg[m_addr] = b;
        8'h04: if (i == 1) begin
                 m_addr = b[1:0];
                 m_txd  = (m_addr == 2'd3) ? (STATUS_EN ? m_status : 8'h00) : m_reg[m_addr];
               end else if (i == 2 && m_addr == 2'd3) begin
                 m_status = 8'h00;
               end
        default: ;
      endcase
    end
    e.txd = m_txd; e.ctrl = m_reg[0]; e.adiv = m_reg[1]; e.ddiv = m_reg[2];
  endtask

  // Monitor: one cycle after each tagged byte the DUT response is compared to the queued prediction.
  logic tag = 1'b0, tag_q = 1'b0;
  always @(posedge clk) tag_q <= tag;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn) begin
      if (tag_q) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("byte resp: txd=%02h pop=%0b wr=%0b wdata=%02h", txd_data, adc_pop, dac_wr, dac_wdata);
          chk("txd_data", txd_data, e.txd);
          chk("adc_pop", adc_pop, e.pop);
          chk("dac_wr", dac_wr, e.wr);
          if (e.wr) chk("dac_wdata", dac_wdata, e.wdata);
          chk("run_bits", {dac_run, adc_run}, e.ctrl[1:0]);
          chk("adc_div", adc_div, e.adiv);
          chk("dac_div", dac_div, e.ddiv);
        end
      end else begin
        chk("idle_strobes", {dac_wr, adc_pop}, 2'b00);
      end
    end
  end

  task automatic send_byte(input int i, input logic [7:0] b, input bit rdy);
    exp_t e;
    @(negedge clk);
    model_byte(i, b, rdy, e);
    exp_q.push_back(e);
    rxd_out = b; dac_ready = rdy; rxd_flag = 1'b1; tag = 1'b1;
    @(negedge clk);
    rxd_flag = 1'b0; tag = 1'b0; rxd_out = 8'($urandom);
    repeat (3) @(negedge clk);
  endtask

  logic [7:0] fr_b [8];
  logic [7:0] fr_rdy;
  int         fr_n;

  task automatic run_frame();
    @(negedge clk) spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_in_frame", busy, 1);
    for (int i = 0; i < fr_n; i++) send_byte(i, fr_b[i], fr_rdy[i]);
    repeat (2) @(negedge clk);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    m_txd = 8'h00;
    chk("busy_after_cs", busy, 0);
    chk("txd_after_cs", txd_data, m_txd);
    chk("regs_after_cs", {dac_run, adc_run, adc_div, dac_div}, {m_reg[0][1:0], m_reg[1], m_reg[2]});
    chk("sb_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Directed frame of up to 4 bytes; byte 0 is the top byte of 'bytes', rdy bit i goes with byte i.
  task automatic frame4(input int n, input logic [31:0] bytes, input logic [3:0] rdy);
    for (int i = 0; i < 4; i++) fr_b[i] = bytes[31-8*i -: 8];
    fr_rdy = {4'b0, rdy};
    fr_n   = n;
    run_frame();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int op;
    resetn = 1'b0; spi_cs = 1'b1; rxd_flag = 1'b0; rxd_out = 8'h00; dac_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_outputs", {txd_data, adc_pop, dac_wr, dac_wdata, adc_run, dac_run, adc_div, dac_div, busy}, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    frame4(3, 32'h03_00_03_00, 4'hF);
    chk("tp_run_bits", {dac_run, adc_run}, 2'b11);
    frame4(3, 32'h04_00_5A_00, 4'hF);
    frame4(4, 32'h01_10_20_30, 4'b1111);
    frame4(4, 32'h01_10_20_30, 4'b1011);
    frame4(3, 32'h04_03_00_00, 4'hF);
    frame4(3, 32'h04_03_00_00, 4'hF);
    adc_push(8'hA1); adc_push(8'hA2);
    frame4(4, 32'h02_33_44_55, 4'hF);
    frame4(3, 32'h04_03_00_00, 4'hF);
    frame4(2, 32'h7F_55_00_00, 4'hF);
    frame4(3, 32'h04_03_00_00, 4'hF);
    frame4(2, 32'h03_01_00_00, 4'hF);
    chk("tp_partial_wr", adc_div, 8'h00);

    // Bytes arriving with CS high must be ignored.
    adc_push(8'hC7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rxd_out = 8'h01 + 8'(k); dac_ready = 1'b1; rxd_flag = 1'b1;
      @(negedge clk) rxd_flag = 1'b0;
      repeat (3) @(negedge clk);
      chk("cs_high_busy", busy, 0);
      chk("cs_high_txd", txd_data, m_txd);
      chk("cs_high_regs", {dac_run, adc_run, adc_div, dac_div}, {m_reg[0][1:0], m_reg[1], m_reg[2]});
    end

    // Reset in the middle of a DAC stream.
    @(negedge clk) spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(0, 8'h01, 1'b1);
    send_byte(1, 8'h10, 1'b1);
    resetn = 1'b0; spi_cs = 1'b1;
    #1;
    chk("midrst_outputs", {txd_data, adc_pop, dac_wr, dac_wdata, adc_run, dac_run, adc_div, dac_div, busy}, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk) resetn = 1'b1;
    repeat (3) @(negedge clk);
    frame4(2, 32'h01_77_00_00, 4'hF);

    for (int f = 0; f < 80; f++) begin
      repeat ($urandom_range(0, 3)) adc_push(8'($urandom));
      op = $urandom_range(0, 4);
      fr_n = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) fr_b[i] = 8'($urandom);
      fr_b[0] = (op == 0) ? (8'h05 + 8'($urandom_range(0, 250))) : 8'(op);
      fr_rdy = 8'($urandom) | 8'($urandom);
      run_frame();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
